regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port successor to the single-read-pair register file; sits between decode and execute.
- Provides NUM_READ registered read ports, NUM_WRITE writeback ports, write-first bypass and a predicate (ps) flag.
- Adds a per-register busy scoreboard and a sequential post-reset clear walk, so large register arrays need no async reset.

Parameters:
- DATA_WIDTH, 16, width of each register.
- NUM_REGS, 16, register count (power of 2, >= 2).
- NUM_READ, 2, read ports.
- NUM_WRITE, 2, write ports; higher index has priority.
- ADDR_WIDTH, $clog2(NUM_REGS), derived and not to be overridden.

Ports:
- clk  in  1  sole clock.
- n_rst  in  1  reset; asynchronous, active-low.
- rd_valid  in  NUM_READ  per-port read request.
- rd_addr  in  NUM_READ x ADDR_WIDTH  read addresses.
- rd_data  out  NUM_READ x DATA_WIDTH  registered read data.
- ps_read  in  1  request ps sample.
- ps_out  out  1  registered ps value.
- wr_valid  in  NUM_WRITE  per-port write enable.
- wr_addr  in  NUM_WRITE x ADDR_WIDTH  write addresses.
- wr_data  in  NUM_WRITE x DATA_WIDTH  write data.
- ps_wr_valid  in  1  ps write enable.
- ps_wr_data  in  1  ps write value.
- busy_set  in  1  mark rd register pending (instruction issue).
- busy_addr  in  ADDR_WIDTH  register to mark.
- busy  out  NUM_REGS  scoreboard vector; bit i = register i awaiting writeback.
- ready  out  1  high once clear walk is done.

Behaviour:
- Interface: one clock (clk); reset n_rst is asynchronous and active-low.
- On n_rst low (async):
  - FSM=INIT, clear counter=0.
  - ready=0, busy=0, ps=0, ps_out=0, rd_data=0.
- The register array has no reset.
- INIT:
  - Each cycle writes 0 to entry clr_cnt, then clr_cnt++.
  - Last entry cleared when clr_cnt==NUM_REGS-1; next state RUN. INIT lasts exactly NUM_REGS cycles after reset release.
  - wr_valid, busy_set, ps_wr_valid, rd_valid and ps_read are ignored; rd_data holds 0.
- RUN: ready=1; no exit except reset.
- Reset asserted mid-INIT or mid-RUN: restart INIT at 0.
- Read latency 1:
  - rd_valid[p] at cycle t gives rd_data[p] at t+1.
  - rd_valid low: rd_data[p] holds its previous value.
  - ps_read behaves the same way for ps_out.
- Write: array updated at the clock edge.
- Write-first bypass: a read at t of an address written at t returns wr_data.
  - With several writes to that address, the highest-index write port's data is returned.
- Same-address multi-write: highest-index port wins in both the array and the bypass.
- ps: ps_wr_valid updates the ps flag; a simultaneous ps_read returns ps_wr_data.
- Scoreboard:
  - Any valid write to address a clears busy[a].
  - busy_set sets busy[busy_addr].
  - Set and clear on the same address in the same cycle: set wins (new producer overrides the old one).
  - busy updates one cycle after the event.
- Addresses are always in range; no wrap handling is needed.

Optional Feature:
- REGFILE_ZERO_REG_EN defined:
  - Register 0 is hardwired to 0.
  - Writes to address 0 are dropped and do not bypass.
  - Reads of address 0 return 0.
  - busy[0] is held 0; busy_set on address 0 is ignored.
- REGFILE_ZERO_REG_EN undefined: register 0 is ordinary storage.

Decomposition:
- Shared package regfile_pkg:
  - State enum rf_state_e {RF_INIT, RF_RUN}.
  - Typedef rf_addr_t and typedef rf_data_t, sized from global DATA_WIDTH/NUM_REGS defaults.
- Sub-module rf_scoreboard: busy vector with set/clear priority.
- Array, bypass and FSM stay in the top module.

Test Plan:
- Reset release, NUM_REGS=16 -> ready low for 16 cycles, high on cycle 17; any read then returns 0; wr_valid during INIT leaves the array unchanged.
- In RUN, write port 0 (addr 5, 16'hBEEF) while rd port 1 reads addr 5 in the same cycle -> rd_data[1]=16'hBEEF next cycle; a later read also returns 16'hBEEF.
- Ports 0 and 1 both write addr 3 (16'h1111 and 16'h2222) -> array and bypass give 16'h2222.
- busy_set addr 7 -> busy[7]=1; write addr 7 with busy_set addr 7 in the same cycle -> busy[7] stays 1; a lone write to addr 7 -> busy[7]=0.
- Assert n_rst mid-RUN with busy=16'h00F0 -> busy=0 and ready=0 immediately (async); a full INIT walk follows.
- With REGFILE_ZERO_REG_EN: write addr 0 = 16'hFFFF, then read addr 0 -> 0; without the macro -> 16'hFFFF.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg -- shared types for the multi-port register file.
//   rf_state_e : clear-walk FSM states (RF_INIT walks the array to zero,
//                RF_RUN is normal operation).
//   rf_data_t / rf_addr_t : register word and index sized from the default
//                geometry (16 x 16-bit).
package regfile_pkg;

  localparam int RF_DATA_WIDTH = 16;
  localparam int RF_NUM_REGS   = 16;
  localparam int RF_NUM_READ   = 2;
  localparam int RF_NUM_WRITE  = 2;
  localparam int RF_ADDR_WIDTH = $clog2(RF_NUM_REGS);

  typedef logic [RF_DATA_WIDTH-1:0] rf_data_t;
  typedef logic [RF_ADDR_WIDTH-1:0] rf_addr_t;

  typedef enum logic {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_e;

endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if -- bundle of all read, write, predicate and scoreboard
// signals between decode/execute (master) and the register file (slave).
//
// Handshake: every request is valid-only. A *_valid / ps_read / busy_set
// bit high at a rising clk edge is a request taken on that edge; there is
// no ready/backpressure per request. The single 'ready' output only tells
// the master that the post-reset clear walk has finished; requests made
// while ready is low are ignored.
//
//   rd_valid/rd_addr -> rd_data   : NUM_READ read ports, data one cycle later
//   ps_read          -> ps_out    : predicate sample, one cycle later
//   wr_valid/wr_addr/wr_data      : NUM_WRITE write ports, higher index wins
//   ps_wr_valid/ps_wr_data        : predicate write
//   busy_set/busy_addr -> busy    : pending-writeback scoreboard
//   ready                         : clear walk done
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int NUM_REGS   = RF_NUM_REGS,
  parameter int NUM_READ   = RF_NUM_READ,
  parameter int NUM_WRITE  = RF_NUM_WRITE,
  localparam int ADDR_WIDTH = $clog2(NUM_REGS)
);

  logic [NUM_READ-1:0]                  rd_valid;
  logic [NUM_READ-1:0][ADDR_WIDTH-1:0]  rd_addr;
  logic [NUM_READ-1:0][DATA_WIDTH-1:0]  rd_data;
  logic                                 ps_read;
  logic                                 ps_out;
  logic [NUM_WRITE-1:0]                 wr_valid;
  logic [NUM_WRITE-1:0][ADDR_WIDTH-1:0] wr_addr;
  logic [NUM_WRITE-1:0][DATA_WIDTH-1:0] wr_data;
  logic                                 ps_wr_valid;
  logic                                 ps_wr_data;
  logic                                 busy_set;
  logic [ADDR_WIDTH-1:0]                busy_addr;
  logic [NUM_REGS-1:0]                  busy;
  logic                                 ready;

  modport master (
    output rd_valid, rd_addr, ps_read,
    output wr_valid, wr_addr, wr_data, ps_wr_valid, ps_wr_data,
    output busy_set, busy_addr,
    input  rd_data, ps_out, busy, ready
  );

  modport slave (
    input  rd_valid, rd_addr, ps_read,
    input  wr_valid, wr_addr, wr_data, ps_wr_valid, ps_wr_data,
    input  busy_set, busy_addr,
    output rd_data, ps_out, busy, ready
  );

endinterface

// File: rtl/rf_scoreboard.sv
// rf_scoreboard -- per-register "awaiting writeback" vector.
//   clk, n_rst : clock, async active-low reset (busy clears to 0)
//   clr_vec    : one bit per register written this cycle
//   set_en     : an instruction issued this cycle targets set_addr
//   set_addr   : register being claimed
//   busy       : registered scoreboard, updates one cycle after the event
// A set and a clear of the same register in one cycle leaves it set: the
// newly issued producer supersedes the one whose result just landed.
module rf_scoreboard #(
  parameter int NUM_REGS = 16,
  parameter bit ZERO_REG = 1'b0,
  localparam int ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic [NUM_REGS-1:0]   clr_vec,
  input  logic                  set_en,
  input  logic [ADDR_WIDTH-1:0] set_addr,
  output logic [NUM_REGS-1:0]   busy
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [NUM_REGS-1:0] set_vec;

  always_comb begin
    set_vec = '0;
    if (set_en) set_vec[set_addr] = 1'b1;
    busy_d = (busy_q & ~clr_vec) | set_vec;
    // A hardwired zero register never has a pending producer.
    if (ZERO_REG) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp -- parametrised multi-port register file between decode and
// execute.
//   clk, n_rst : clock, asynchronous active-low reset
//   bus        : regfile_mp_if.slave (read/write/ps/scoreboard/ready)
//   dbg_state  : current clear-walk FSM state
//
// The array itself has no reset. After n_rst releases, RF_INIT writes zero
// to one entry per cycle (NUM_REGS cycles), then RF_RUN accepts traffic.
// Reads are registered with write-first bypass; among writes to one
// address the highest-index port wins, both in the array and the bypass.
//
// Build option: define REGFILE_ZERO_REG_EN to hardwire register 0 to zero
// (writes dropped, no bypass, busy[0] held low).
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int NUM_REGS   = RF_NUM_REGS,
  parameter int NUM_READ   = RF_NUM_READ,
  parameter int NUM_WRITE  = RF_NUM_WRITE,
  localparam int ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic         clk,
  input  logic         n_rst,
  regfile_mp_if.slave  bus,
  output rf_state_e    dbg_state
);

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

  rf_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                  clr_we;
  logic                  run;

  logic [DATA_WIDTH-1:0]                mem [NUM_REGS];
  logic [NUM_WRITE-1:0]                 wr_en;
  logic [NUM_READ-1:0][DATA_WIDTH-1:0]  rd_next;
  logic [NUM_READ-1:0][DATA_WIDTH-1:0]  rd_q;
  logic                                 ps_q;
  logic                                 ps_out_q;
  logic [NUM_REGS-1:0]                  clr_vec;
  logic                                 set_en;

  // ---------------- clear-walk FSM ----------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= RF_INIT;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_we    = 1'b0;
    if (state_q == RF_INIT) begin
      clr_we    = 1'b1;
      clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
      if (clr_cnt_q == LAST_IDX) state_d = RF_RUN;
    end
  end

  assign run       = (state_q == RF_RUN);
  assign dbg_state = state_q;
  assign bus.ready = run;

  // ---------------- write side ----------------
  always_comb begin
    wr_en   = '0;
    clr_vec = '0;
    for (int w = 0; w < NUM_WRITE; w++) begin
      wr_en[w] = bus.wr_valid[w] && run &&
                 !(ZERO_REG && (bus.wr_addr[w] == '0));
      if (wr_en[w]) clr_vec[bus.wr_addr[w]] = 1'b1;
    end
  end

  // Later loop iterations override earlier ones, so the highest-index port
  // wins on a shared address. clr_we and wr_en are never both active.
  always_ff @(posedge clk) begin
    if (clr_we) mem[clr_cnt_q] <= '0;
    for (int w = 0; w < NUM_WRITE; w++) begin
      if (wr_en[w]) mem[bus.wr_addr[w]] <= bus.wr_data[w];
    end
  end

  // ---------------- read side with write-first bypass ----------------
  always_comb begin
    rd_next = '0;
    for (int p = 0; p < NUM_READ; p++) begin
      rd_next[p] = mem[bus.rd_addr[p]];
      for (int w = 0; w < NUM_WRITE; w++) begin
        if (wr_en[w] && (bus.wr_addr[w] == bus.rd_addr[p]))
          rd_next[p] = bus.wr_data[w];
      end
      if (ZERO_REG && (bus.rd_addr[p] == '0)) rd_next[p] = '0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_q     <= '0;
      ps_q     <= 1'b0;
      ps_out_q <= 1'b0;
    end else begin
      for (int p = 0; p < NUM_READ; p++) begin
        if (run && bus.rd_valid[p]) rd_q[p] <= rd_next[p];
      end
      if (run && bus.ps_wr_valid) ps_q <= bus.ps_wr_data;
      if (run && bus.ps_read)
        ps_out_q <= bus.ps_wr_valid ? bus.ps_wr_data : ps_q;
    end
  end

  assign bus.rd_data = rd_q;
  assign bus.ps_out  = ps_out_q;

  // ---------------- scoreboard ----------------
  assign set_en = run && bus.busy_set && !(ZERO_REG && (bus.busy_addr == '0));

  rf_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .n_rst    (n_rst),
    .clr_vec  (clr_vec),
    .set_en   (set_en),
    .set_addr (bus.busy_addr),
    .busy     (bus.busy)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp -- self-checking bench for regfile_mp (16 x 16-bit, 2R/2W).
// A reference model (array, ps flag, busy vector, clear-walk countdown)
// predicts each cycle's outputs; predictions are queued before the clock
// edge and popped/compared one step after it.
module tb_regfile_mp;
  import regfile_pkg::*;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO = 1'b1;
`else
  localparam bit ZERO = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic n_rst;
  rf_state_e dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  regfile_mp_if bus ();

  regfile_mp dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- checking ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  rf_data_t        mdl_mem [16];
  logic            mdl_ps;
  logic [15:0]     mdl_busy;
  rf_data_t        hold_rd [2];
  logic            hold_ps;
  int              init_left;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mdl_mem[i] = '0;
    mdl_ps    = 1'b0;
    mdl_busy  = '0;
    hold_rd[0] = '0;
    hold_rd[1] = '0;
    hold_ps   = 1'b0;
    init_left = 16;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    bus.rd_valid    = '0;
    bus.rd_addr     = '0;
    bus.ps_read     = 1'b0;
    bus.wr_valid    = '0;
    bus.wr_addr     = '0;
    bus.wr_data     = '0;
    bus.ps_wr_valid = 1'b0;
    bus.ps_wr_data  = 1'b0;
    bus.busy_set    = 1'b0;
    bus.busy_addr   = '0;
  endtask

  // One clock: predict from the driven inputs, clock, compare, commit.
  task automatic tick();
    rf_data_t    nxt [16];
    rf_data_t    erd;
    logic        nps, eps;
    logic [15:0] nb;
    bit          run;
    logic [31:0] obs [5];
    run = (init_left == 0);
    nxt = mdl_mem;
    nb  = mdl_busy;
    nps = mdl_ps;
    if (run) begin
      for (int w = 0; w < 2; w++)
        if (bus.wr_valid[w] && !(ZERO && bus.wr_addr[w] == 4'd0))
          nxt[bus.wr_addr[w]] = bus.wr_data[w];
      for (int w = 0; w < 2; w++)
        if (bus.wr_valid[w]) nb[bus.wr_addr[w]] = 1'b0;
      if (bus.busy_set && !(ZERO && bus.busy_addr == 4'd0))
        nb[bus.busy_addr] = 1'b1;
      if (bus.ps_wr_valid) nps = bus.ps_wr_data;
    end
    for (int p = 0; p < 2; p++) begin
      erd = (run && bus.rd_valid[p]) ? nxt[bus.rd_addr[p]] : hold_rd[p];
      hold_rd[p] = erd;
      exp_q.push_back({16'h0, erd});
      tag_q.push_back(p == 0 ? "rd_data0" : "rd_data1");
    end
    eps = (run && bus.ps_read) ? nps : hold_ps;
    hold_ps = eps;
    exp_q.push_back({31'h0, eps});      tag_q.push_back("ps_out");
    exp_q.push_back({16'h0, nb});       tag_q.push_back("busy");
    if (init_left > 0) init_left--;
    exp_q.push_back({31'h0, (init_left == 0)}); tag_q.push_back("ready");

    @(posedge clk);
    #1;
    obs[0] = {16'h0, bus.rd_data[0]};
    obs[1] = {16'h0, bus.rd_data[1]};
    obs[2] = {31'h0, bus.ps_out};
    obs[3] = {16'h0, bus.busy};
    obs[4] = {31'h0, bus.ready};
    for (int k = 0; k < 5; k++) check(tag_q.pop_front(), obs[k], exp_q.pop_front());
    check("dbg_state", {31'h0, dbg_state}, {31'h0, (init_left == 0)});

    mdl_mem  = nxt;
    mdl_ps   = nps;
    mdl_busy = nb;
  endtask

  task automatic rd2(input logic [3:0] a0, input logic [3:0] a1);
    bus.rd_valid   = 2'b11;
    bus.rd_addr[0] = a0;
    bus.rd_addr[1] = a1;
  endtask

  // Asserts n_rst between edges and checks outputs before any clock edge.
  task automatic async_reset();
    #2;
    n_rst = 1'b0;
    #1;
    check("rst_ready",  {31'h0, bus.ready},     32'h0);
    check("rst_busy",   {16'h0, bus.busy},      32'h0);
    check("rst_rd0",    {16'h0, bus.rd_data[0]}, 32'h0);
    check("rst_rd1",    {16'h0, bus.rd_data[1]}, 32'h0);
    check("rst_ps_out", {31'h0, bus.ps_out},    32'h0);
    model_reset();
    @(posedge clk);
    #3;
    n_rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    idle();
    n_rst = 1'b1;
    async_reset();

    // Clear walk with junk traffic that must be ignored.
    for (int i = 0; i < 16; i++) begin
      rd2(4'd2, 4'd9);
      bus.ps_read     = 1'b1;
      bus.wr_valid    = 2'b11;
      bus.wr_addr[0]  = 4'd2;  bus.wr_data[0] = 16'hDEAD;
      bus.wr_addr[1]  = 4'd9;  bus.wr_data[1] = 16'hBEAD;
      bus.ps_wr_valid = 1'b1;  bus.ps_wr_data = 1'b1;
      bus.busy_set    = 1'b1;  bus.busy_addr = 4'd4;
      tick();
      check("init_ready", {31'h0, bus.ready}, {31'h0, (i == 15)});
    end
    idle();

    // Every register reads back zero after the walk.
    for (int r = 0; r < 16; r += 2) begin
      rd2(4'(r), 4'(r + 1));
      tick();
      check("walk_zero", {16'h0, bus.rd_data[0] | bus.rd_data[1]}, 32'h0);
    end
    idle();

    // Write-first bypass, then a plain read.
    bus.wr_valid = 2'b01; bus.wr_addr[0] = 4'd5; bus.wr_data[0] = 16'hBEEF;
    bus.rd_valid = 2'b10; bus.rd_addr[1] = 4'd5;
    tick();
    check("bypass_beef", {16'h0, bus.rd_data[1]}, 32'h0000BEEF);
    idle();
    rd2(4'd5, 4'd5);
    tick();
    check("array_beef", {16'h0, bus.rd_data[0]}, 32'h0000BEEF);
    idle();

    // Same-address double write: port 1 wins.
    bus.wr_valid = 2'b11;
    bus.wr_addr[0] = 4'd3; bus.wr_data[0] = 16'h1111;
    bus.wr_addr[1] = 4'd3; bus.wr_data[1] = 16'h2222;
    bus.rd_valid = 2'b01; bus.rd_addr[0] = 4'd3;
    tick();
    check("bypass_2222", {16'h0, bus.rd_data[0]}, 32'h00002222);
    idle();
    rd2(4'd1, 4'd3);
    tick();
    check("array_2222", {16'h0, bus.rd_data[1]}, 32'h00002222);
    idle();

    // Scoreboard set / set-beats-clear / clear.
    bus.busy_set = 1'b1; bus.busy_addr = 4'd7;
    tick();
    check("busy7_set", {31'h0, bus.busy[7]}, 32'h1);
    bus.wr_valid = 2'b10; bus.wr_addr[1] = 4'd7; bus.wr_data[1] = 16'h0777;
    tick();
    check("busy7_setwins", {31'h0, bus.busy[7]}, 32'h1);
    idle();
    bus.wr_valid = 2'b01; bus.wr_addr[0] = 4'd7; bus.wr_data[0] = 16'h7777;
    tick();
    check("busy7_clear", {31'h0, bus.busy[7]}, 32'h0);
    idle();

    // Predicate: write with simultaneous read, then read alone.
    bus.ps_wr_valid = 1'b1; bus.ps_wr_data = 1'b1; bus.ps_read = 1'b1;
    tick();
    check("ps_bypass", {31'h0, bus.ps_out}, 32'h1);
    idle();
    tick();
    bus.ps_read = 1'b1;
    tick();
    check("ps_stored", {31'h0, bus.ps_out}, 32'h1);
    idle();

    // Random traffic, narrow address range to force collisions.
    for (int i = 0; i < 300; i++) begin
      bus.rd_valid    = 2'($urandom_range(0, 3));
      bus.rd_addr[0]  = 4'($urandom_range(0, 15));
      bus.rd_addr[1]  = 4'($urandom_range(0, 7));
      bus.wr_valid    = 2'($urandom_range(0, 3));
      bus.wr_addr[0]  = 4'($urandom_range(0, 7));
      bus.wr_addr[1]  = 4'($urandom_range(0, 7));
      bus.wr_data[0]  = 16'($urandom_range(0, 65535));
      bus.wr_data[1]  = 16'($urandom_range(0, 65535));
      bus.ps_read     = 1'($urandom_range(0, 1));
      bus.ps_wr_valid = 1'($urandom_range(0, 1));
      bus.ps_wr_data  = 1'($urandom_range(0, 1));
      bus.busy_set    = 1'($urandom_range(0, 1));
      bus.busy_addr   = 4'($urandom_range(0, 15));
      tick();
    end
    idle();

    // Drain the scoreboard, then mark 4..7 busy.
    for (int r = 0; r < 16; r += 2) begin
      bus.wr_valid = 2'b11;
      bus.wr_addr[0] = 4'(r);     bus.wr_data[0] = 16'(r * 16'h0101);
      bus.wr_addr[1] = 4'(r + 1); bus.wr_data[1] = 16'((r + 1) * 16'h0101);
      tick();
    end
    idle();
    for (int r = 4; r < 8; r++) begin
      bus.busy_set = 1'b1; bus.busy_addr = 4'(r);
      tick();
    end
    idle();
    check("busy_00f0", {16'h0, bus.busy}, 32'h000000F0);

    // Mid-RUN reset and a full second walk.
    async_reset();
    for (int i = 0; i < 16; i++) begin
      bus.wr_valid = 2'b01; bus.wr_addr[0] = 4'(i); bus.wr_data[0] = 16'hA5A5;
      tick();
    end
    idle();
    for (int r = 0; r < 16; r += 2) begin
      rd2(4'(r), 4'(r + 1));
      tick();
    end
    idle();

    // Register 0 behaviour depends on the build option.
    bus.wr_valid = 2'b01; bus.wr_addr[0] = 4'd0; bus.wr_data[0] = 16'hFFFF;
    tick();
    idle();
    bus.rd_valid = 2'b01; bus.rd_addr[0] = 4'd0;
    tick();
    check("reg0_read", {16'h0, bus.rd_data[0]}, ZERO ? 32'h0 : 32'h0000FFFF);
    idle();
    bus.busy_set = 1'b1; bus.busy_addr = 4'd0;
    tick();
    check("reg0_busy", {31'h0, bus.busy[0]}, ZERO ? 32'h0 : 32'h1);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
